// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared constants and segment table for the PS/2 keyboard display
package ps2_kbd_pkg;

    localparam int FRAME_BITS = 11;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit0=a ... bit6=g
    function automatic logic [6:0] seg7_of(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - one active-low hex digit driver with blanking
module hex_to_seg7
    import ps2_kbd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       en,
    output logic [6:0] seg
);

    assign seg = en ? seg7_of(nibble) : SEG_BLANK;

endmodule

// File: rtl/ps2_kbd_seg.sv
// rtl/ps2_kbd_seg.sv - PS/2 keyboard receiver with two-digit hex display; PS2_PARITY_CHK_EN enables parity rejection
module ps2_kbd_seg
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       seg_en,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic [6:0] seg_lo,
    output logic [6:0] seg_hi
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic [3:0]             bit_cnt;
    logic [FRAME_BITS-2:0]  shreg;
    logic [TO_W-1:0]        to_cnt;

    logic                  clk_s;
    logic                  data_s;
    logic                  fall;
    logic                  last_bit;
    logic [FRAME_BITS-1:0] frame;
    logic                  par_ok;
    logic                  frame_ok;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign fall     = clk_prev & ~clk_s;
    assign last_bit = (bit_cnt == 4'(FRAME_BITS - 1));
    assign frame    = {data_s, shreg};

`ifdef PS2_PARITY_CHK_EN
    assign par_ok = ^frame[9:1];
`else
    // Parity bit is still shifted in, just not judged
    assign par_ok = frame[9] | 1'b1;
`endif

    assign frame_ok = ~frame[0] & frame[10] & par_ok;

    // Synchronisers idle high so reset does not fake a falling edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            to_cnt     <= '0;
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (last_bit) begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                    if (frame_ok) begin
                        code       <= frame[8:1];
                        code_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {data_s, shreg[FRAME_BITS-2:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is dropped silently
                if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    to_cnt  <= '0;
                    bit_cnt <= '0;
                    shreg   <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    hex_to_seg7 u_seg_lo (
        .nibble (code[3:0]),
        .en     (seg_en),
        .seg    (seg_lo)
    );

    hex_to_seg7 u_seg_hi (
        .nibble (code[7:4]),
        .en     (seg_en),
        .seg    (seg_hi)
    );

endmodule

// File: tb/tb_ps2_kbd_seg.sv
// tb/tb_ps2_kbd_seg.sv - directed self-checking bench for ps2_kbd_seg
module tb_ps2_kbd_seg;

    localparam int TO_CYC = 300;

    logic       clk;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       seg_en;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;
    logic [6:0] seg_lo;
    logic [6:0] seg_hi;

    int total = 0;
    int bad   = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int cv0;
    int fe0;

    ps2_kbd_seg #(
        .TIMEOUT_CYC (TO_CYC),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .seg_en     (seg_en),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .seg_lo     (seg_lo),
        .seg_hi     (seg_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid) cv_cnt++;
        if (frame_err) fe_cnt++;
        if (code_valid && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // nbits < 11 sends a truncated frame
    task automatic send(input logic [7:0] d, input logic pflip, input logic stop_b, input int nbits);
        logic [10:0] f;
        f = {stop_b, (~^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (4) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (8) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(posedge clk);
        end
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        resetn   = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        seg_en   = 1'b1;
        repeat (3) @(posedge clk);
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_code", code, 8'h00);
        chk("rst_seg_lo", seg_lo, 7'h40);
        chk("rst_seg_hi", seg_hi, 7'h40);
        chk("rst_cv", cv_cnt, 0);
        chk("rst_fe", fe_cnt, 0);

        send(8'h1C, 1'b0, 1'b1, 11);
        chk("1c_code", code, 8'h1C);
        chk("1c_cv", cv_cnt, 1);
        chk("1c_seg_hi", seg_hi, 7'h79);
        chk("1c_seg_lo", seg_lo, 7'h46);

        cv0 = cv_cnt;
        send(8'hF0, 1'b0, 1'b1, 11);
        chk("f0_code", code, 8'hF0);
        chk("f0_seg_hi", seg_hi, 7'h0E);
        chk("f0_seg_lo", seg_lo, 7'h40);
        send(8'h16, 1'b0, 1'b1, 11);
        chk("16_code", code, 8'h16);
        chk("16_seg_lo", seg_lo, 7'h02);
        chk("b2b_cv", cv_cnt - cv0, 2);

        cv0 = cv_cnt;
        send(8'h16, 1'b0, 1'b1, 11);
        chk("dup_cv", cv_cnt - cv0, 1);

        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send(8'h1C, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHK_EN
        chk("par_code", code, 8'h16);
        chk("par_fe", fe_cnt - fe0, 1);
        chk("par_cv", cv_cnt - cv0, 0);
`else
        chk("par_code", code, 8'h1C);
        chk("par_fe", fe_cnt - fe0, 0);
        chk("par_cv", cv_cnt - cv0, 1);
`endif

        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send(8'hAA, 1'b0, 1'b0, 11);
        chk("stop_fe", fe_cnt - fe0, 1);
        chk("stop_cv", cv_cnt - cv0, 0);
        chk("stop_code_held", code != 8'hAA, 1);

        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send(8'h99, 1'b0, 1'b1, 5);
        repeat (TO_CYC + 10) @(posedge clk);
        send(8'h45, 1'b0, 1'b1, 11);
        chk("to_code", code, 8'h45);
        chk("to_fe", fe_cnt - fe0, 0);
        chk("to_cv", cv_cnt - cv0, 1);
        chk("45_seg_hi", seg_hi, 7'h19);

        seg_en = 1'b0;
        #1;
        chk("blank_lo", seg_lo, 7'h7F);
        chk("blank_hi", seg_hi, 7'h7F);
        send(8'h33, 1'b0, 1'b1, 11);
        chk("blank_code", code, 8'h33);

        send(8'h77, 1'b0, 1'b1, 4);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_code", code, 8'h00);
        repeat (3) @(posedge clk);
        resetn = 1'b1;
        seg_en = 1'b1;
        repeat (5) @(posedge clk);
        cv0 = cv_cnt;
        send(8'h5A, 1'b0, 1'b1, 11);
        chk("after_rst_code", code, 8'h5A);
        chk("after_rst_cv", cv_cnt - cv0, 1);
        chk("5a_seg_hi", seg_hi, 7'h12);
        chk("5a_seg_lo", seg_lo, 7'h08);

        chk("never_both", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_seg.md
Name: ps2_kbd_seg

Overview:
- PS/2 keyboard receiver plus hex-to-seven-segment display driver.
- Deserialises PS/2 device-to-host frames, holds the last valid scan code, and drives two active-low 7-segment digits showing that code in hex.
- Sits between the board PS/2 pins and the segment displays; downstream ASCII mapping and break-code (0xF0) handling consume `code`/`code_valid`.

Parameters:
- TIMEOUT_CYC, 50000, idle clk cycles mid-frame before the partial frame is discarded (1 ms at 50 MHz).
- SYNC_STAGES, 2, flops per synchroniser on ps2_clk/ps2_data; minimum 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock from keyboard, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- seg_en  in  1  1 = digits show code, 0 = digits blanked
- code  out  8  last valid scan code received
- code_valid  out  1  one-cycle pulse when code updates
- frame_err  out  1  one-cycle pulse on a rejected frame
- seg_lo  out  7  active-low segments for code[3:0]; bit0=a ... bit6=g
- seg_hi  out  7  active-low segments for code[7:4]

Behaviour:
- Interface: one clock `clk`; reset `resetn` is asynchronous and active-low.
- Reset values: code=0x00, code_valid=0, frame_err=0, bit counter=0, shift register=0, timeout counter=0, synchroniser flops=1 (idle bus).
- After reset with seg_en=1, both digits show "0" (7'h40).
- Synchronise ps2_clk and ps2_data through SYNC_STAGES flops each.
- A falling edge is synced ps2_clk going 1 to 0 between consecutive clk cycles. Sample synced ps2_data on each falling edge.
- Frame format: 11 bits, LSB-first:
  - start (must be 0)
  - data[0..7]
  - parity (odd over data + parity)
  - stop (must be 1)
- Bit counter runs 0..10 and increments per sampled bit. On the 11th sample the counter returns to 0 and the frame is evaluated.
- Valid frame (start=0, parity odd, stop=1): on the clk edge after the 11th sample, code loads data and code_valid=1 for exactly one cycle.
- Invalid frame: frame_err=1 for one cycle; code holds; code_valid stays 0.
- code_valid and frame_err are never high together.
- Timeout: while counter is not 0, a timeout counter increments each cycle without a falling edge and clears on each falling edge.
  - On reaching TIMEOUT_CYC, the counter and shift register clear.
  - No pulse is generated; the next falling edge is treated as a start bit.
- Back-to-back frames: each frame is evaluated independently. The same code received twice still pulses code_valid twice.
- Reset asserted mid-frame: discard the partial frame; all state returns to reset values immediately.
- Segment encoding is combinational from code and seg_en; no added latency. Nibble values 0..F map to:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- seg_en=0: seg_lo=seg_hi=7'h7F (all segments off); code keeps updating.

Optional Feature:
- Macro PS2_PARITY_CHK_EN.
- Defined: a parity mismatch rejects the frame (frame_err pulse, code held).
- Undefined: parity is ignored; only start=0 and stop=1 are checked. The parity bit is still consumed as bit 9.

Decomposition:
- Package ps2_kbd_pkg holds:
  - FRAME_BITS=11
  - SEG_BLANK=7'h7F
  - the 16-entry segment constant table as a function seg7_of(nibble)
- One sub-module, hex_to_seg7 (nibble, en → seg[6:0]), instantiated twice for seg_lo/seg_hi.

Test Plan:
- Reset, seg_en=1, no traffic → code=0x00, seg_lo=seg_hi=7'h40, no pulses.
- Send frame 0x1C, parity 0 → code=0x1C, one code_valid pulse, seg_hi=7'h79, seg_lo=7'h46.
- Send 0xF0 (parity 1), then 0x16 (parity 0) back-to-back → code=0xF0 with seg_hi=7'h0E, seg_lo=7'h40; then code=0x16; two pulses.
- Send 0x1C with parity bit 1 (macro defined) → one frame_err pulse, code unchanged; same frame with macro undefined → code=0x1C.
- Send 5 bits, idle TIMEOUT_CYC+10 cycles, then full 0x45 frame (parity 0) → code=0x45, no frame_err.
- Drop seg_en to 0 → seg_lo=seg_hi=7'h7F; assert resetn=0 mid-frame → code=0x00 immediately, next full frame decodes correctly.
